// File: rtl/adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_ctrl_pkg
//  Description : Shared state encoding and timing defaults for the adder
//                ring-oscillator measurement sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_SETTLE  = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    localparam int unsigned c_CLEAR_CYC_DEF  = 2;
    localparam int unsigned c_SETTLE_CYC_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/adder_measure_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adder_measure_ctrl
//  Description : Clears the adder edge counter, runs the ring for a programmed
//                window, lets it settle and captures the edge count.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_measure_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RES_W      = 32,
    parameter int unsigned SETTLE_CYC = c_SETTLE_CYC_DEF,
    parameter int unsigned CLEAR_CYC  = c_CLEAR_CYC_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] window_len,
    input  logic [RES_W-1:0] ring_count,
    output logic             ring_en,
    output logic             count_clear,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [RES_W-1:0] result
);

    // One phase counter serves CLEAR, RUN and SETTLE, so it must hold the widest load.
    localparam int unsigned c_PH_MAX = (CLEAR_CYC > SETTLE_CYC) ? CLEAR_CYC : SETTLE_CYC;
    localparam int unsigned c_PH_W   = $clog2(c_PH_MAX + 1);
    localparam int unsigned c_CW     = (CNT_W > c_PH_W) ? CNT_W : c_PH_W;

    localparam logic [c_CW-1:0] c_CLEAR_LOAD  = c_CW'(CLEAR_CYC - 1);
    localparam logic [c_CW-1:0] c_SETTLE_LOAD = c_CW'(SETTLE_CYC - 1);
    localparam logic [c_CW-1:0] c_ONE         = c_CW'(1);

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic [CNT_W-1:0]  win_q, win_d;
    logic [c_CW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic              ring_en_q, ring_en_d;
    logic              count_clear_q, count_clear_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              w_start_pulse;
    logic              w_cnt_zero;

    always_comb begin
        state_d       = state_q;
        start_d       = start;
        win_d         = win_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        result_d      = result_q;
        w_start_pulse = start & ~start_q;
        w_cnt_zero    = (cnt_q == '0);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (w_start_pulse) begin
                    win_d = window_len;
                    if (window_len == '0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = c_CLEAR_LOAD;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (w_cnt_zero) begin
                    // Window is nonzero here, so win-1 cannot underflow.
                    cnt_d   = c_CW'(win_q) - c_ONE;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (w_cnt_zero) begin
                    cnt_d   = c_SETTLE_LOAD;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (w_cnt_zero) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = ring_count;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs decode the next state so they line up with the registered state.
        ring_en_d     = (state_d == S_RUN);
        count_clear_d = (state_d == S_CLEAR);
        busy_d        = (state_d == S_CLEAR) || (state_d == S_RUN) ||
                        (state_d == S_SETTLE) || (state_d == S_CAPTURE);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b1;
            win_q         <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            result_q      <= '0;
            ring_en_q     <= 1'b0;
            count_clear_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            win_q         <= win_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            result_q      <= result_d;
            ring_en_q     <= ring_en_d;
            count_clear_q <= count_clear_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign ring_en     = ring_en_q;
    assign count_clear = count_clear_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign result      = result_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_measure_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_measure_ctrl
//  Description : Self-checking bench for adder_measure_ctrl against a
//                timeline model of one measurement.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_measure_ctrl;

    localparam int c_CLR = 2;
    localparam int c_SET = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] window_len;
    logic [31:0] ring_count;
    logic        ring_en;
    logic        count_clear;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;

    adder_measure_ctrl #(
        .CNT_W      (16),
        .RES_W      (32),
        .SETTLE_CYC (c_SET),
        .CLEAR_CYC  (c_CLR)
    ) u_dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start       (start),
        .abort       (abort),
        .window_len  (window_len),
        .ring_count  (ring_count),
        .ring_en     (ring_en),
        .count_clear (count_clear),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Measurement model: a run is a start edge at edge index t0 followed by a
    // fixed timeline (clear, window, settle, capture) measured in edges.
    int          n          = 0;
    bit          m_prev_st  = 1'b1;
    bit          m_active   = 1'b0;
    int          m_t0       = 0;
    int          m_win      = 0;
    bit          m_done     = 1'b0;
    bit          m_err      = 1'b0;
    logic [31:0] m_result   = '0;
    int          ren_cycles = 0;

    task automatic tick();
        bit pulse;
        int o;
        int len;
        bit e_cc, e_ren, e_busy, e_done;
        @(posedge clk);
        n++;
        pulse     = start && !m_prev_st;
        m_prev_st = start;
        len       = c_CLR + m_win + c_SET + 1;
        if (rst) begin
            m_prev_st = 1'b1;
            m_active  = 1'b0;
            m_done    = 1'b0;
            m_err     = 1'b0;
            m_result  = '0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 1'b0;
                m_done   = 1'b0;
            end else if (n - m_t0 == len) begin
                m_result = ring_count;
                m_done   = 1'b1;
                m_active = 1'b0;
            end
        end else if (abort) begin
            m_done = 1'b0;
        end else if (pulse) begin
            m_win = int'(window_len);
            if (m_win == 0) begin
                m_err  = 1'b1;
                m_done = 1'b1;
            end else begin
                m_err    = 1'b0;
                m_done   = 1'b0;
                m_active = 1'b1;
                m_t0     = n;
            end
        end
        if (m_active) begin
            o      = n - m_t0;
            e_cc   = (o < c_CLR);
            e_ren  = (o >= c_CLR) && (o < c_CLR + m_win);
            e_busy = 1'b1;
            e_done = 1'b0;
        end else begin
            e_cc   = 1'b0;
            e_ren  = 1'b0;
            e_busy = 1'b0;
            e_done = m_done;
        end
        #1;
        if (ring_en) ren_cycles++;
        check_val("ring_en", 32'(ring_en), 32'(e_ren));
        check_val("count_clear", 32'(count_clear), 32'(e_cc));
        check_val("busy", 32'(busy), 32'(e_busy));
        check_val("done", 32'(done), 32'(e_done));
        check_val("err", 32'(err), 32'(m_err));
        check_val("result", result, m_result);
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        window_len = '0;
        ring_count = '0;
        ticks(3);
        rst = 1'b0;
        ticks(2);

        // Basic window of 10 with a static count after the ring stops
        window_len = 16'd10;
        ren_cycles = 0;
        start      = 1'b1;
        tick();
        window_len = 16'd7;
        ticks(12);
        ring_count = 32'h0000_1234;
        ticks(4);
        check_val("basic_busy_before_done", 32'(busy), 32'd1);
        tick();
        check_val("basic_done_at_17", 32'(done), 32'd1);
        check_val("basic_result", result, 32'h0000_1234);
        check_val("basic_ren_count", 32'(ren_cycles), 32'd10);
        ticks(2);

        // Zero window
        start      = 1'b0;
        window_len = 16'd0;
        tick();
        start      = 1'b1;
        ren_cycles = 0;
        tick();
        check_val("zero_err", 32'(err), 32'd1);
        check_val("zero_result_kept", result, 32'h0000_1234);
        ticks(3);
        check_val("zero_no_ring", 32'(ren_cycles), 32'd0);

        // Abort on RUN cycle 20 of a 100-cycle window
        start      = 1'b0;
        window_len = 16'd100;
        tick();
        start = 1'b1;
        tick();
        ticks(c_CLR + 19);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_ring_off", 32'(ring_en), 32'd0);
        check_val("abort_done_low", 32'(done), 32'd0);
        ticks(5);

        // Start held high through reset release
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(6);
        check_val("held_start_idle", 32'(busy), 32'd0);
        start      = 1'b0;
        window_len = 16'd4;
        tick();
        start = 1'b1;
        ticks(c_CLR + 4 + c_SET + 3);

        // Second edge during RUN is ignored; new start after DONE reruns with 3
        start      = 1'b0;
        window_len = 16'd10;
        tick();
        ren_cycles = 0;
        start      = 1'b1;
        ticks(c_CLR + 3);
        start = 1'b0;
        tick();
        start = 1'b1;
        ticks(c_CLR + 10 + c_SET + 2);
        check_val("retrig_one_window", 32'(ren_cycles), 32'd10);
        start      = 1'b0;
        window_len = 16'd3;
        tick();
        ren_cycles = 0;
        start      = 1'b1;
        tick();
        check_val("rerun_done_cleared", 32'(done), 32'd0);
        ticks(c_CLR + 3 + c_SET + 2);
        check_val("rerun_ren_count", 32'(ren_cycles), 32'd3);

        // Simultaneous abort and start in IDLE
        abort = 1'b1;
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        abort = 1'b0;
        ticks(3);
        check_val("abort_start_busy", 32'(busy), 32'd0);

        // Maximum window must run its full length
        start      = 1'b0;
        window_len = 16'hFFFF;
        tick();
        ren_cycles = 0;
        start      = 1'b1;
        tick();
        for (int i = 0; i < 65535 + c_CLR + c_SET + 3; i++) begin
            window_len = 16'($urandom);
            ring_count = $urandom;
            tick();
        end
        check_val("max_window_len", 32'(ren_cycles), 32'd65535);

        // Random mix of starts, aborts, resets and window lengths
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) start = ~start;
            abort      = ($urandom_range(0, 59) == 0);
            rst        = ($urandom_range(0, 799) == 0);
            window_len = 16'($urandom_range(0, 12));
            ring_count = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_measure_ctrl.md
Name: adder_measure_ctrl

Overview:
- Measurement sequencer for the instrumented adder ring-oscillator datapath in the wrapped user project.
- On a start request from the logic analyser, it does the following in order:
  - clears the adder's edge counter;
  - enables the ring for a programmed number of wb_clk_i cycles;
  - waits for the ring to settle;
  - captures the counter into a result register and flags done.
- Sits between the LA/IO pins of the wrapper and the instrumented adder instance.

Parameters:
- CNT_W, 16, width of window_len and the internal window counter.
- RES_W, 32, width of ring_count and result.
- SETTLE_CYC, 4, cycles between ring_en falling and result capture (must be >=1).
- CLEAR_CYC, 2, cycles count_clear is held high before the ring is enabled (must be >=1).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- start  in  1  level from LA; a measurement starts on a 0->1 edge
- abort  in  1  level; cancels any measurement in progress
- window_len  in  CNT_W  ring enable window in wb_clk_i cycles; sampled on the start edge
- ring_count  in  RES_W  edge counter value from the instrumented adder; static once the ring is stopped
- ring_en  out  1  enables the ring oscillator
- count_clear  out  1  synchronous clear to the adder edge counter
- busy  out  1  high in CLEAR, RUN, SETTLE and CAPTURE
- done  out  1  high in DONE; held until the next start edge or abort
- err  out  1  set when the last start had window_len==0
- result  out  RES_W  last captured ring_count

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is synchronous and active-high on wb_rst_i. Reset forces the following:
  - state=IDLE;
  - ring_en=0, count_clear=0, busy=0, done=0, err=0, result=0;
  - start_q=1, so a start held high through reset release does not trigger.
- Edge detect: start_pulse = start & ~start_q, with start_q registered every cycle.
- States: IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE. All outputs are registered, one state-derived decode per state.
- IDLE/DONE: on start_pulse, latch window_len into win_reg and clear done.
  - If window_len==0: err<=1, go to DONE. result is unchanged, ring is never enabled.
  - Else: err<=0, go to CLEAR.
  - start_pulse is ignored in all other states.
- CLEAR: count_clear=1 for exactly CLEAR_CYC cycles, then go to RUN.
- RUN: ring_en=1 for exactly win_reg cycles, counted by a down-counter loaded with win_reg. Then go to SETTLE.
- SETTLE: ring_en=0 for exactly SETTLE_CYC cycles, then go to CAPTURE.
- CAPTURE: one cycle; result<=ring_count; go to DONE.
- Latency: the first DONE cycle is CLEAR_CYC+win_reg+SETTLE_CYC+1 cycles after the edge that detected start_pulse. With defaults and W=10, that is 17 cycles.
- Max window: win_reg=2^CNT_W-1 runs its full length. The window counter must not wrap or terminate early.
- abort:
  - In CLEAR, RUN, SETTLE or CAPTURE: next state is IDLE. ring_en and count_clear go to 0 on the same edge. done=0. result and err keep their previous values. A capture is not performed if abort coincides with CAPTURE.
  - In IDLE/DONE: clears done, goes to IDLE.
  - abort and start_pulse in the same cycle: abort wins and the start is discarded. start must fall and rise again to retrigger.
- Reset mid-measurement: same as the reset values above. ring_en drops on that edge.
- Invariants:
  - ring_en and count_clear are never high together.
  - busy and done are never high together.
  - ring_en is never high outside RUN.
- window_len changes after the start edge have no effect on the measurement in progress.

Decomposition:
- Package adder_ctrl_pkg holds:
  - the state enumeration (IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE, 3-bit encoding);
  - default constants for CLEAR_CYC and SETTLE_CYC.
- Single module. No sub-module is natural; the edge detector and the counters are a few lines each.
- The wrapper instantiates this block inside the project and drives start/abort/window_len from la1_data_in bits. result is driven out on la1_data_out.

Test Plan:
- Basic: reset, window_len=10, start 0->1, ring_count=0x1234 driven static after ring_en falls. Expect:
  - count_clear high 2 cycles, then ring_en high exactly 10 cycles, then 4 cycles idle;
  - result=0x1234 and done=1 on the 17th cycle after the start edge;
  - busy low in the DONE cycle.
- Zero window: window_len=0, start edge. Expect err=1 and done=1 next cycle, ring_en never high, result unchanged.
- Abort during RUN: window_len=100, assert abort on RUN cycle 20. Expect ring_en=0 and state IDLE next cycle, done=0, result still the prior value.
- Start held through reset: start=1 while wb_rst_i deasserts. Expect no measurement. A later 0->1 edge starts one measurement.
- Retrigger and ignore: second start edge during RUN is ignored (one ring_en window only). After DONE, a new start edge clears done and reruns with the newly sampled window_len=3 (ring_en exactly 3 cycles).
- Simultaneous abort+start in IDLE: no CLEAR entered, done stays 0, busy stays 0.
